// File: rtl/mem_arb_pkg.sv
// Shared encodings and default sizing for the fetch / load-store memory port arbiter.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_WAIT = ST_WAIT,
        S_RESP = ST_RESP
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    localparam int unsigned MEM_LAT_DEF    = 2;
    localparam int unsigned STARVE_MAX_DEF = 4;

    // Both the latency counter and the starvation counter cover the 1..15 range.
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select between fetch and load/store, with the fetch starvation counter.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic ls_req,
    input  logic arb_en,
    output logic sel_if,
    output logic sel_ls
);

    logic [CNT_W-1:0] starve_cnt;
    logic             if_forced;

    always_comb begin
        if_forced = (starve_cnt == CNT_W'(STARVE_MAX));
        sel_ls    = arb_en && ls_req && !(if_req && if_forced);
        sel_if    = arb_en && if_req && !sel_ls;
    end

    // A load/store win over a waiting fetch implies !if_forced, so the count
    // stops at STARVE_MAX without a separate saturation test.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (sel_if) begin
            starve_cnt <= '0;
        end else if (sel_ls && if_req) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter: one access in flight, fixed latency, response
// routed back to whichever side was granted.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_be,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] lat_cnt, lat_cnt_nxt;
    logic             owner, owner_nxt;
    logic             owner_st, owner_st_nxt;
    logic             arb_en, sel_if, sel_ls, resp;

    // Grants only from IDLE and never while reset is held.
    assign arb_en = rst_n && (state == S_IDLE);

    mem_arb_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clk   (clk),
        .rst_n (rst_n),
        .if_req(if_req),
        .ls_req(ls_req),
        .arb_en(arb_en),
        .sel_if(sel_if),
        .sel_ls(sel_ls)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt    = state;
        lat_cnt_nxt  = lat_cnt;
        owner_nxt    = owner;
        owner_st_nxt = owner_st;
        unique case (state)
            S_IDLE: begin
                if (sel_if || sel_ls) begin
                    owner_nxt    = sel_ls ? OWN_LS : OWN_IF;
                    owner_st_nxt = sel_ls && ls_we;
                    if (MEM_LAT > 1) begin
                        state_nxt   = S_WAIT;
                        lat_cnt_nxt = CNT_W'(MEM_LAT - 1);
                    end else begin
                        state_nxt = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                lat_cnt_nxt = lat_cnt - 1'b1;
                if (lat_cnt == CNT_W'(1)) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: only control state is reset; the data path is combinational and needs none.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            lat_cnt  <= '0;
            owner    <= OWN_IF;
            owner_st <= 1'b0;
        end else begin
            state    <= state_nxt;
            lat_cnt  <= lat_cnt_nxt;
            owner    <= owner_nxt;
            owner_st <= owner_st_nxt;
        end
    end

    always_comb begin
        if_gnt    = sel_if;
        ls_gnt    = sel_ls;
        mem_en    = sel_if || sel_ls;
        mem_we    = sel_ls && ls_we;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (sel_ls) begin
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
            mem_be    = ls_be;
        end else if (sel_if) begin
            mem_addr = if_addr;
        end

        resp      = rst_n && (state == S_RESP);
        if_rvalid = resp && (owner == OWN_IF);
        ls_rvalid = resp && (owner == OWN_LS);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        // Store completion carries no data.
        ls_rdata  = (ls_rvalid && !owner_st) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 uses MEM_LAT=2, instance 1 uses MEM_LAT=1,
// both with STARVE_MAX=4; a cycle model is compared every cycle plus literal pins.
module tb_mem_port_arbiter;

    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       if_req, ls_req, ls_we;
    logic [1:0][31:0] if_addr, ls_addr, ls_wdata;
    logic [1:0][3:0]  ls_be, mem_be;
    logic [1:0]       if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we;
    logic [1:0][31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]       any_out;

    int n_vec = 0;
    int n_bad = 0;

    // Memory contents as a pure function of address; 0x10 holds the test-plan word.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h10) ? 32'h0051_0093 : ((a ^ 32'hA5A5_0000) | 32'h1);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] last_addr = '0;

        mem_port_arbiter #(
            .ADDR_W(32), .DATA_W(32), .MEM_LAT((g == 0) ? 2 : 1), .STARVE_MAX(SMAX)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
            .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
            .ls_req(ls_req[g]), .ls_we(ls_we[g]), .ls_addr(ls_addr[g]),
            .ls_wdata(ls_wdata[g]), .ls_be(ls_be[g]), .ls_gnt(ls_gnt[g]),
            .ls_rvalid(ls_rvalid[g]), .ls_rdata(ls_rdata[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_be(mem_be[g]), .mem_rdata(mem_rdata[g])
        );

        // Memory macro stand-in: data for the last issued address stays on the bus.
        always @(posedge clk) if (mem_en[g]) last_addr <= mem_addr[g];
        assign mem_rdata[g] = mem_fn(last_addr);
        assign any_out[g] = |{if_gnt[g], if_rvalid[g], if_rdata[g], ls_gnt[g], ls_rvalid[g],
                              ls_rdata[g], mem_en[g], mem_we[g], mem_addr[g], mem_wdata[g], mem_be[g]};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a transaction is either absent or has a count of cycles left until its
    // response; arbitration only happens when nothing is in flight.
    int          lat_of [2] = '{2, 1};
    bit          m_busy [2];
    int          m_rem [2];
    int          m_starve [2];
    bit          m_own_ls [2];
    bit          m_own_st [2];
    logic [31:0] m_own_addr [2];

    initial for (int k = 0; k < 2; k++) begin
        m_busy[k] = 0; m_rem[k] = 0; m_starve[k] = 0;
        m_own_ls[k] = 0; m_own_st[k] = 0; m_own_addr[k] = '0;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic        e_ig, e_lg, e_irv, e_lrv, e_en, e_we;
            logic [31:0] e_ird, e_lrd, e_addr, e_wd;
            logic [3:0]  e_be;
            string       p;
            e_ig = 0; e_lg = 0; e_irv = 0; e_lrv = 0; e_en = 0; e_we = 0;
            e_ird = '0; e_lrd = '0; e_addr = '0; e_wd = '0; e_be = '0;
            if (!rst_n) begin
                m_busy[k] = 0;
                m_starve[k] = 0;
            end else if (!m_busy[k]) begin
                if (ls_req[k] && !(if_req[k] && m_starve[k] == SMAX)) begin
                    e_lg = 1; e_en = 1; e_we = ls_we[k];
                    e_addr = ls_addr[k]; e_wd = ls_wdata[k]; e_be = ls_be[k];
                    if (if_req[k] && m_starve[k] < SMAX) m_starve[k]++;
                    m_own_ls[k] = 1; m_own_st[k] = ls_we[k]; m_own_addr[k] = ls_addr[k];
                end else if (if_req[k]) begin
                    e_ig = 1; e_en = 1; e_addr = if_addr[k];
                    m_starve[k] = 0;
                    m_own_ls[k] = 0; m_own_st[k] = 0; m_own_addr[k] = if_addr[k];
                end
                if (e_en) begin
                    m_busy[k] = 1;
                    m_rem[k] = lat_of[k] - 1;
                end
            end else if (m_rem[k] == 0) begin
                if (m_own_ls[k]) begin
                    e_lrv = 1;
                    e_lrd = m_own_st[k] ? 32'h0 : mem_fn(m_own_addr[k]);
                end else begin
                    e_irv = 1;
                    e_ird = mem_fn(m_own_addr[k]);
                end
                m_busy[k] = 0;
            end else begin
                m_rem[k]--;
            end
            p = $sformatf("dut%0d.", k);
            check({p, "if_gnt"}, if_gnt[k], e_ig);
            check({p, "ls_gnt"}, ls_gnt[k], e_lg);
            check({p, "if_rvalid"}, if_rvalid[k], e_irv);
            check({p, "if_rdata"}, if_rdata[k], e_ird);
            check({p, "ls_rvalid"}, ls_rvalid[k], e_lrv);
            check({p, "ls_rdata"}, ls_rdata[k], e_lrd);
            check({p, "mem_en"}, mem_en[k], e_en);
            check({p, "mem_we"}, mem_we[k], e_we);
            check({p, "mem_addr"}, mem_addr[k], e_addr);
            check({p, "mem_wdata"}, mem_wdata[k], e_wd);
            check({p, "mem_be"}, mem_be[k], e_be);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #3;
    endtask

    initial begin
        if_req = '0; ls_req = '0; ls_we = '0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_be = '0;

        // Reset with a fetch already requesting: nothing may be granted.
        tick(); if_req[0] = 1; if_addr[0] = 32'h10;
        tick(); mid();
        check("rst.outs_zero0", any_out[0], 0);
        check("rst.outs_zero1", any_out[1], 0);
        check("rst.no_gnt", if_gnt[0], 0);

        // Lone fetch, and an ls request withdrawn during WAIT.
        tick(); rst_n = 1; mid();
        check("f1.if_gnt_T", if_gnt[0], 1);
        check("f1.mem_en_T", mem_en[0], 1);
        check("f1.mem_addr_T", mem_addr[0], 32'h10);
        tick(); if_req[0] = 0; ls_req[0] = 1; ls_addr[0] = 32'h300; mid();
        check("f1.ls_gnt_wait", ls_gnt[0], 0);
        check("f1.if_rvalid_T1", if_rvalid[0], 0);
        tick(); ls_req[0] = 0; mid();
        check("f1.if_rvalid_T2", if_rvalid[0], 1);
        check("f1.if_rdata_T2", if_rdata[0], 32'h0051_0093);
        check("f1.ls_rvalid_T2", ls_rvalid[0], 0);

        // Simultaneous requests: load wins, fetch granted at T+3.
        tick(); if_req[0] = 1; if_addr[0] = 32'h20; ls_req[0] = 1; ls_addr[0] = 32'h100; mid();
        check("both.ls_gnt_T", ls_gnt[0], 1);
        check("both.if_gnt_T", if_gnt[0], 0);
        check("both.mem_addr_T", mem_addr[0], 32'h100);
        tick(); ls_req[0] = 0; mid();
        check("both.if_gnt_T1", if_gnt[0], 0);
        tick(); mid();
        check("both.ls_rvalid_T2", ls_rvalid[0], 1);
        check("both.ls_rdata_T2", ls_rdata[0], 32'hA5A5_0101);
        check("both.if_rvalid_T2", if_rvalid[0], 0);
        tick(); mid();
        check("both.if_gnt_T3", if_gnt[0], 1);
        check("both.mem_addr_T3", mem_addr[0], 32'h20);
        tick(); if_req[0] = 0;
        tick(); mid();
        check("both.if_rvalid_T5", if_rvalid[0], 1);
        check("both.if_rdata_T5", if_rdata[0], 32'hA5A5_0021);

        // Both held: four load/store grants, fetch on the fifth, load/store on the sixth.
        tick(); if_req[0] = 1; if_addr[0] = 32'h30; ls_req[0] = 1; ls_addr[0] = 32'h104;
        for (int g = 0; g < 6; g++) begin
            if (g > 0) repeat (3) tick();
            mid();
            check($sformatf("starve.ls_gnt%0d", g), ls_gnt[0], (g != 4));
            check($sformatf("starve.if_gnt%0d", g), if_gnt[0], (g == 4));
        end
        tick(); if_req[0] = 0; ls_req[0] = 0;
        tick();

        // Byte-masked store: completion pulse carries zero data.
        tick(); ls_req[0] = 1; ls_we[0] = 1; ls_addr[0] = 32'h200;
        ls_wdata[0] = 32'hDEAD_BEEF; ls_be[0] = 4'b0011; mid();
        check("st.ls_gnt", ls_gnt[0], 1);
        check("st.mem_we", mem_we[0], 1);
        check("st.mem_be", mem_be[0], 4'b0011);
        check("st.mem_wdata", mem_wdata[0], 32'hDEAD_BEEF);
        check("st.mem_addr", mem_addr[0], 32'h200);
        tick(); ls_req[0] = 0; ls_we[0] = 0; ls_wdata[0] = '0; ls_be[0] = '0;
        tick(); mid();
        check("st.ls_rvalid", ls_rvalid[0], 1);
        check("st.ls_rdata", ls_rdata[0], 32'h0);

        // Reset during WAIT drops the fetch; a new fetch is granted right after release.
        tick(); if_req[0] = 1; if_addr[0] = 32'h40; mid();
        check("rw.if_gnt", if_gnt[0], 1);
        tick(); if_req[0] = 0; rst_n = 0; mid();
        check("rw.outs_zero", any_out[0], 0);
        tick(); mid();
        check("rw.no_rvalid", if_rvalid[0], 0);
        tick(); rst_n = 1; if_req[0] = 1; if_addr[0] = 32'h44; mid();
        check("rw.regnt", if_gnt[0], 1);
        check("rw.regnt_addr", mem_addr[0], 32'h44);
        tick(); if_req[0] = 0; mid();
        check("rw.no_early_rvalid", if_rvalid[0], 0);
        tick(); mid();
        check("rw.if_rvalid", if_rvalid[0], 1);
        check("rw.if_rdata", if_rdata[0], 32'hA5A5_0045);

        // MEM_LAT=1: back-to-back fetches, no grant in RESP.
        tick(); if_req[1] = 1; if_addr[1] = 32'h80; mid();
        check("l1.if_gnt_T", if_gnt[1], 1);
        tick(); if_addr[1] = 32'h84; mid();
        check("l1.if_gnt_T1", if_gnt[1], 0);
        check("l1.if_rvalid_T1", if_rvalid[1], 1);
        check("l1.if_rdata_T1", if_rdata[1], 32'hA5A5_0081);
        tick(); mid();
        check("l1.if_gnt_T2", if_gnt[1], 1);
        check("l1.mem_addr_T2", mem_addr[1], 32'h84);
        tick(); if_req[1] = 0; mid();
        check("l1.if_gnt_T3", if_gnt[1], 0);
        check("l1.if_rvalid_T3", if_rvalid[1], 1);
        check("l1.if_rdata_T3", if_rdata[1], 32'hA5A5_0085);

        // MEM_LAT=1 contention.
        tick(); if_req[1] = 1; if_addr[1] = 32'h88; ls_req[1] = 1; ls_addr[1] = 32'h108; mid();
        check("l1b.ls_gnt", ls_gnt[1], 1);
        tick(); ls_req[1] = 0; mid();
        check("l1b.ls_rvalid", ls_rvalid[1], 1);
        check("l1b.ls_rdata", ls_rdata[1], 32'hA5A5_0109);
        check("l1b.if_gnt_resp", if_gnt[1], 0);
        tick(); mid();
        check("l1b.if_gnt", if_gnt[1], 1);
        tick(); if_req[1] = 0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
